// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, wrap-around sequencing and IF/ID register
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect raises a sticky fetch_fault and freezes fetch)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] seq_next;
  logic [31:0] redirect_pc;

  // Sequential successor wraps to zero at the last word of instruction memory
  always_comb begin
    seq_next    = (pc == LAST_PC) ? 32'h0000_0000 : pc + 32'd4;
    redirect_pc = redirect_target & 32'hFFFF_FFFC;
    imem_addr   = pc & 32'hFFFF_FFFC;
  end

  // PC and IF/ID update; priority reset > (fault) > redirect > flush > stall > normal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      ifid_pc     <= 32'h0000_0000;
      ifid_pc4    <= 32'h0000_0000;
      ifid_instr  <= NOP;
      ifid_valid  <= 1'b0;
      fetch_count <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end
`ifdef MISALIGN_TRAP_EN
    else if (fetch_fault || (redirect_valid && (redirect_target[1:0] != 2'b00))) begin
      // Sticky trap: PC frozen and the IF/ID register keeps emitting bubbles until reset
      fetch_fault <= 1'b1;
      ifid_valid  <= 1'b0;
      ifid_instr  <= NOP;
    end
`endif
    else if (redirect_valid) begin
      pc         <= redirect_pc;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
    end else if (flush) begin
      pc         <= seq_next;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
    end else if (!stall) begin
      pc          <= seq_next;
      ifid_pc     <= pc;
      ifid_pc4    <= seq_next;
      ifid_instr  <= imem_rdata;
      ifid_valid  <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit with a behavioural reference model
module tb_fetch_unit;

  localparam int IMEM_BYTES = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr, fetch_count;
  logic        ifid_valid;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [0:15];

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_count;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[5:2]];

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count)
`ifdef MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wrap_next(input logic [31:0] p);
    // word index advances modulo the memory size
    return ((p / 4 + 1) % (IMEM_BYTES / 4)) * 4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_count = 32'h0; m_fault = 1'b0;
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    check("ifid_instr", ifid_instr, m_instr);
    check("fetch_count", fetch_count, m_count);
    if (m_valid) begin
      check("ifid_pc", ifid_pc, m_ipc);
      check("ifid_pc4", ifid_pc4, m_ipc4);
    end
`ifdef MISALIGN_TRAP_EN
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare mid-cycle
  task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] rt);
    logic misaligned;
    stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
    @(posedge clk);
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned = rv && (rt % 4 != 0);
`endif
    if (m_fault || misaligned) begin
      m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else if (rv) begin
      m_pc = (rt / 4) * 4; m_valid = 1'b0; m_instr = NOP;
    end else if (f) begin
      m_pc = wrap_next(m_pc); m_valid = 1'b0; m_instr = NOP;
    end else if (!s) begin
      m_ipc = m_pc; m_ipc4 = wrap_next(m_pc); m_instr = mem[m_pc / 4];
      m_valid = 1'b1; m_count = m_count + 1; m_pc = wrap_next(m_pc);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'hFF71_8393;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    reset_n = 1'b1;
    @(negedge clk);
    do_reset();

    // First fetch after reset comes from RESET_PC
    step(0, 0, 0, 32'h0);
    check("first_ifid_pc", ifid_pc, 32'h0);
    check("first_ifid_instr", ifid_instr, 32'hFF71_8393);
    check("first_ifid_valid", {31'b0, ifid_valid}, 32'h1);
    check("first_imem_addr", imem_addr, 32'h4);
    check("first_fetch_count", fetch_count, 32'h1);

    // Wrap at the last word
    step(0, 0, 1, 32'd60);
    step(0, 0, 0, 32'h0);
    check("wrap_imem_addr", imem_addr, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'd60);
    check("wrap_ifid_pc4", ifid_pc4, 32'h0);

    // Redirect beats stall
    step(0, 0, 1, 32'h8);
    step(1, 0, 1, 32'h20);
    check("redir_imem_addr", imem_addr, 32'h20);
    check("redir_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    check("redir_ifid_instr", ifid_instr, 32'h13);
    check("redir_fetch_count", fetch_count, 32'h2);

    // Three-edge stall at pc=12
    step(0, 0, 1, 32'h8);
    step(0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 32'h0);
      check("stall_imem_addr", imem_addr, 32'd12);
      check("stall_ifid_pc", ifid_pc, 32'd8);
      check("stall_fetch_count", fetch_count, 32'd3);
    end
    step(0, 0, 0, 32'h0);
    check("unstall_ifid_pc", ifid_pc, 32'd12);

    // Flush at pc=16
    step(0, 1, 0, 32'h0);
    check("flush_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    check("flush_ifid_instr", ifid_instr, 32'h13);
    check("flush_imem_addr", imem_addr, 32'd20);

`ifdef MISALIGN_TRAP_EN
    step(0, 0, 1, 32'h22);
    check("trap_fault", {31'b0, fetch_fault}, 32'h1);
    check("trap_imem_addr", imem_addr, 32'd20);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h8);
    check("trap_frozen_addr", imem_addr, 32'd20);
    check("trap_frozen_valid", {31'b0, ifid_valid}, 32'h0);
    do_reset();
    check("trap_cleared", {31'b0, fetch_fault}, 32'h0);
    check("trap_reset_pc", imem_addr, 32'h0);
`endif

    // Randomized traffic with an occasional mid-cycle reset
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tgt;
      tgt = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
`ifndef MISALIGN_TRAP_EN
      tgt[1:0] = 2'($urandom);
`endif
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, tgt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
